// File: rtl/iiravg_sched_pkg.sv
// Shared widths and helpers for the time-shared recursive-average engine.
// Anything that sizes ports or per-channel state derives from these functions.
package iiravg_pkg;

    function automatic int aw_calc(input int iw, input int ow, input int lg);
        return ((iw > ow) ? iw : ow) + lg;
    endfunction

    function automatic int gear_width(input int lg);
        return $clog2(lg + 1);
    endfunction

    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NCH_DEFAULT     = 4;
    localparam int LGALPHA_DEFAULT = 4;
    localparam int GW_DEFAULT      = gear_width(LGALPHA_DEFAULT);
    localparam int CW_DEFAULT      = chan_width(NCH_DEFAULT);

endpackage

// File: rtl/iiravg_sched_if.sv
// Request/grant, restart and tagged-result bundle between the estimators and the averager.
// Signal prefixes are from the averager's point of view.
interface iiravg_sched_if
    import iiravg_pkg::*;
#(
    parameter int NCH = 4,
    parameter int IW  = 15,
    parameter int OW  = 16,
    parameter int CW  = chan_width(NCH)
);
    logic [NCH-1:0]    i_valid;
    logic [NCH*IW-1:0] i_data;
    logic [NCH-1:0]    o_ready;
    logic              i_restart;
    logic [CW-1:0]     i_restart_chan;
    logic              o_valid;
    logic [CW-1:0]     o_chan;
    logic [OW-1:0]     o_data;

    modport master (
        output i_valid, i_data, i_restart, i_restart_chan,
        input  o_ready, o_valid, o_chan, o_data
    );

    modport slave (
        input  i_valid, i_data, i_restart, i_restart_chan,
        output o_ready, o_valid, o_chan, o_data
    );
endinterface

// File: rtl/iiravg_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first unmasked request at or after the pointer.
// The pointer moves past the granted requester only when the grant is accepted.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [N-1:0] i_req,
    input  logic [N-1:0] i_mask,
    input  logic         i_accept,
    output logic [N-1:0] o_grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next;

    always_comb begin
        int idx;
        o_grant = '0;
        w_next  = r_ptr;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(r_ptr) + i) % N;
            if (o_grant == '0 && i_req[idx] && !i_mask[idx] && !i_reset) begin
                o_grant[idx] = 1'b1;
                w_next       = PW'((idx + 1) % N);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)       r_ptr <= '0;
        else if (i_accept) r_ptr <= w_next;
    end
endmodule

// File: rtl/iiravg_sched.sv
// Time-shared recursive average over NCH channels with a gear-shift start-up schedule.
// Three-stage pipeline: handshake, diff, shift/add + writeback; result strobed one cycle later.
module iiravg_sched
    import iiravg_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int IW      = 15,
    parameter int OW      = 16,
    parameter int LGALPHA = 4,
    parameter int AW      = aw_calc(IW, OW, LGALPHA),
    parameter logic [AW-1:0] RESET_VALUE = '0
) (
    input logic           i_clk,
    input logic           i_reset,
    iiravg_sched_if.slave bus
);
    localparam int CW   = chan_width(NCH);
    localparam int GW   = gear_width(LGALPHA);
    localparam int CNTW = (LGALPHA > 0) ? LGALPHA : 1;

    logic [AW-1:0]   r_avg  [NCH];
    logic [GW-1:0]   r_gear [NCH];
    logic [CNTW-1:0] r_cnt  [NCH];

    logic          r_s1_vld, r_s2_vld, r_o_valid;
    logic [CW-1:0] r_s1_chan, r_s2_chan, r_o_chan;
    logic [IW-1:0] r_s1_sample;
    logic [AW-1:0] r_s2_diff, r_s2_avg;
    logic [GW-1:0] r_s2_gear;
    logic [OW-1:0] r_o_data;

    logic [NCH-1:0] w_busy, w_grant;
    logic           w_accept, w_s1_kill, w_s2_kill, w_wb, w_cnt_last;
    logic [CW-1:0]  w_gidx;
    logic [IW-1:0]  w_gsample;
    logic [AW-1:0]  w_diff, w_adj, w_new_avg;

    always_comb begin
        w_busy = '0;
        if (r_s1_vld) w_busy[r_s1_chan] = 1'b1;
        if (r_s2_vld) w_busy[r_s2_chan] = 1'b1;
    end

    rr_arbiter #(.N(NCH)) u_arb (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_req    (bus.i_valid),
        .i_mask   (w_busy),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    // Grants are only issued to requesting channels, so any grant is a completed handshake.
    assign w_accept = |w_grant;

    always_comb begin
        w_gidx = '0;
        for (int c = 0; c < NCH; c++)
            if (w_grant[c]) w_gidx = CW'(c);
    end

    assign w_gsample = bus.i_data[int'(w_gidx)*IW +: IW];

    assign w_s1_kill  = bus.i_restart && (bus.i_restart_chan == r_s1_chan);
    assign w_s2_kill  = bus.i_restart && (bus.i_restart_chan == r_s2_chan);
    assign w_wb       = r_s2_vld && !w_s2_kill;

    assign w_diff     = {r_s1_sample, {(AW-IW){1'b0}}} - r_avg[r_s1_chan];
    assign w_adj      = AW'($signed(r_s2_diff) >>> r_s2_gear);
    assign w_new_avg  = r_s2_avg + w_adj;
    assign w_cnt_last = (32'(r_cnt[r_s2_chan]) == ((32'd1 << r_s2_gear) - 32'd1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1_vld    <= 1'b0;
            r_s2_vld    <= 1'b0;
            r_o_valid   <= 1'b0;
            r_o_chan    <= '0;
            r_o_data    <= '0;
            r_s1_chan   <= '0;
            r_s1_sample <= '0;
            r_s2_chan   <= '0;
            r_s2_diff   <= '0;
            r_s2_avg    <= '0;
            r_s2_gear   <= '0;
            for (int c = 0; c < NCH; c++) begin
                r_avg[c]  <= RESET_VALUE;
                r_gear[c] <= '0;
                r_cnt[c]  <= '0;
            end
        end else begin
            r_s1_vld    <= w_accept && !(bus.i_restart && (bus.i_restart_chan == w_gidx));
            r_s1_chan   <= w_gidx;
            r_s1_sample <= w_gsample;

            r_s2_vld    <= r_s1_vld && !w_s1_kill;
            r_s2_chan   <= r_s1_chan;
            r_s2_diff   <= w_diff;
            r_s2_avg    <= r_avg[r_s1_chan];
            r_s2_gear   <= r_gear[r_s1_chan];

            r_o_valid   <= w_wb;
            if (w_wb) begin
                r_o_chan           <= r_s2_chan;
                r_o_data           <= w_new_avg[AW-1 -: OW];
                r_avg[r_s2_chan]   <= w_new_avg;
                if (r_s2_gear != GW'(LGALPHA)) begin
                    if (w_cnt_last) begin
                        r_gear[r_s2_chan] <= r_s2_gear + GW'(1);
                        r_cnt[r_s2_chan]  <= '0;
                    end else begin
                        r_cnt[r_s2_chan]  <= r_cnt[r_s2_chan] + CNTW'(1);
                    end
                end
            end

            // Placed last so a restart overrides a same-cycle writeback to that channel.
            if (bus.i_restart) begin
                r_avg[bus.i_restart_chan]  <= RESET_VALUE;
                r_gear[bus.i_restart_chan] <= '0;
                r_cnt[bus.i_restart_chan]  <= '0;
            end
        end
    end

    assign bus.o_ready = w_grant;
    assign bus.o_valid = r_o_valid;
    assign bus.o_chan  = r_o_chan;
    assign bus.o_data  = r_o_data;
endmodule

// File: tb/tb_iiravg_sched.sv
// Directed bench for iiravg_sched with hand-computed averages (AW=20, sample << 5 into the accumulator).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_iiravg_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    iiravg_sched_if #(.NCH(4), .IW(15), .OW(16)) bus ();

    iiravg_sched dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic hs(input int ch, input logic [14:0] d, output int hcyc, output bit ok);
        ok   = 1'b0;
        hcyc = -1;
        @(posedge clk); #1;
        bus.i_valid[ch]        = 1'b1;
        bus.i_data[ch*15 +: 15] = d;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.o_ready[ch]) begin
                ok   = 1'b1;
                hcyc = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        bus.i_valid[ch] = 1'b0;
    endtask

    task automatic wait_out(output bit got, output int ocyc, output int och, output logic [15:0] od);
        got  = 1'b0;
        ocyc = -1;
        och  = -1;
        od   = 16'hxxxx;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.o_valid) begin
                got  = 1'b1;
                ocyc = cyc;
                och  = int'(bus.o_chan);
                od   = bus.o_data;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst         = 1'b1;
        bus.i_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pulse_restart(input int ch);
        @(posedge clk); #1;
        bus.i_restart      = 1'b1;
        bus.i_restart_chan = 2'(ch);
        @(posedge clk); #1;
        bus.i_restart      = 1'b0;
    endtask

    task automatic test_reset();
        bus.i_valid = 4'b1111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.o_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b expected 0000", bus.o_ready); end
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid); end
        n_cmp++; if (bus.o_chan !== 2'd0) begin n_bad++; $display("FAIL reset_chan: got %0d expected 0", bus.o_chan); end
        n_cmp++; if (bus.o_data !== 16'h0000) begin n_bad++; $display("FAIL reset_data: got %h expected 0000", bus.o_data); end
        @(posedge clk); #1;
        bus.i_valid = '0;
        rst         = 1'b0;
    endtask

    task automatic test_basic();
        int hc, oc, och; bit ok, got; logic [15:0] od;
        hs(0, 15'h1000, hc, ok);
        wait_out(got, oc, och, od);
        n_cmp++; if (!ok || !got) begin n_bad++; $display("FAIL basic0_handshake: ok=%0b got=%0b expected 1 1", ok, got); end
        n_cmp++; if (oc - hc !== 3) begin n_bad++; $display("FAIL basic0_latency: got %0d expected 3", oc - hc); end
        n_cmp++; if (och !== 0) begin n_bad++; $display("FAIL basic0_chan: got %0d expected 0", och); end
        n_cmp++; if (od !== 16'h2000) begin n_bad++; $display("FAIL basic0_data: got %h expected 2000", od); end
        hs(0, 15'h0000, hc, ok);
        wait_out(got, oc, och, od);
        n_cmp++; if (!ok || !got) begin n_bad++; $display("FAIL basic1_handshake: ok=%0b got=%0b expected 1 1", ok, got); end
        n_cmp++; if (od !== 16'h1000) begin n_bad++; $display("FAIL basic1_data: got %h expected 1000", od); end
    endtask

    task automatic test_gear();
        int hc, oc, och; bit ok, got; logic [15:0] od;
        int bad_const;
        // 14 samples leave the channel in gear 3: 0x8000 - (0x8000 >>> 3) = 0x7000
        pulse_restart(2);
        for (int i = 0; i < 14; i++) begin
            hs(2, 15'h0400, hc, ok);
            wait_out(got, oc, och, od);
        end
        hs(2, 15'h0000, hc, ok);
        wait_out(got, oc, och, od);
        n_cmp++; if (!got || od !== 16'h0700) begin n_bad++; $display("FAIL gear3_probe: got %h expected 0700", od); end
        // 15 samples reach gear 4: 0x8000 - (0x8000 >>> 4) = 0x7800
        pulse_restart(2);
        for (int i = 0; i < 15; i++) begin
            hs(2, 15'h0400, hc, ok);
            wait_out(got, oc, och, od);
        end
        hs(2, 15'h0000, hc, ok);
        wait_out(got, oc, och, od);
        n_cmp++; if (!got || od !== 16'h0780) begin n_bad++; $display("FAIL gear4_probe: got %h expected 0780", od); end
        pulse_restart(2);
        bad_const = 0;
        for (int i = 0; i < 20; i++) begin
            hs(2, 15'h0400, hc, ok);
            wait_out(got, oc, och, od);
            if (!ok || !got || och != 2 || od !== 16'h0800) bad_const++;
        end
        n_cmp++; if (bad_const != 0) begin n_bad++; $display("FAIL gear_constant: got %0d wrong results expected 0", bad_const); end
        hs(2, 15'h0000, hc, ok);
        wait_out(got, oc, och, od);
        n_cmp++; if (!got || od !== 16'h0780) begin n_bad++; $display("FAIL gear_saturate: got %h expected 0780", od); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int c = 0; c < 4; c++) bus.i_data[c*15 +: 15] = 15'((c + 1) * 16'h0100);
        bus.i_valid = 4'b1111;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (k < 12) begin
                n_cmp++;
                if (bus.o_ready !== 4'(1 << (k % 4))) begin
                    n_bad++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, bus.o_ready, 4'(1 << (k % 4)));
                end
            end
            if (k >= 3) begin
                n_cmp++;
                if (bus.o_valid !== 1'b1 || int'(bus.o_chan) != (k - 3) % 4 ||
                    bus.o_data !== 16'(((k - 3) % 4 + 1) * 16'h0200)) begin
                    n_bad++; $display("FAIL rr_result[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h",
                                      k, bus.o_valid, bus.o_chan, bus.o_data, (k - 3) % 4,
                                      16'(((k - 3) % 4 + 1) * 16'h0200));
                end
            end
        end
        @(posedge clk); #1;
        bus.i_valid = '0;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        logic [14:0] tab [5];
        logic [15:0] exp_d [5];
        int hcy [5], ocy [5], och [5];
        logic [15:0] od [5];
        int n, m;
        bit acc;
        tab   = '{15'h1000, 15'h0000, 15'h1800, 15'h0000, 15'h0000};
        exp_d = '{16'h2000, 16'h1000, 16'h2000, 16'h1800, 16'h1200};
        n = 0; m = 0;
        apply_reset();
        bus.i_data[15 +: 15] = tab[0];
        bus.i_valid[1]       = 1'b1;
        for (int k = 0; k < 40 && m < 5; k++) begin
            @(negedge clk);
            if (bus.o_valid) begin
                if (m < 5) begin ocy[m] = cyc; och[m] = int'(bus.o_chan); od[m] = bus.o_data; end
                m++;
            end
            acc = bus.i_valid[1] & bus.o_ready[1];
            if (acc && n < 5) begin hcy[n] = cyc; n++; end
            @(posedge clk); #1;
            if (acc) begin
                if (n < 5) bus.i_data[15 +: 15] = tab[n];
                else       bus.i_valid[1] = 1'b0;
            end
        end
        bus.i_valid[1] = 1'b0;
        n_cmp++; if (n != 5 || m != 5) begin n_bad++; $display("FAIL b2b_count: got %0d/%0d expected 5/5", n, m); end
        if (n == 5 && m == 5) begin
            for (int i = 1; i < 5; i++) begin
                n_cmp++; if (hcy[i] - hcy[i-1] != 3) begin n_bad++; $display("FAIL b2b_spacing[%0d]: got %0d expected 3", i, hcy[i] - hcy[i-1]); end
            end
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (od[i] !== exp_d[i] || och[i] != 1 || ocy[i] - hcy[i] != 3) begin
                    n_bad++; $display("FAIL b2b_result[%0d]: got d=%h ch=%0d lat=%0d expected d=%h ch=1 lat=3",
                                      i, od[i], och[i], ocy[i] - hcy[i], exp_d[i]);
                end
            end
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_restart();
        int hc, oc, och; bit ok, got, rdy; logic [15:0] od;
        hs(3, 15'h0700, hc, ok);
        wait_out(got, oc, och, od);
        n_cmp++; if (!got || och != 3 || od !== 16'h0e00) begin n_bad++; $display("FAIL restart_pre: got ch=%0d d=%h expected ch=3 d=0e00", och, od); end
        hs(3, 15'h0500, hc, ok);
        bus.i_restart      = 1'b1;
        bus.i_restart_chan = 2'd3;
        @(posedge clk); #1;
        bus.i_restart      = 1'b0;
        wait_out(got, oc, och, od);
        n_cmp++; if (!ok || got) begin n_bad++; $display("FAIL restart_inflight: ok=%0b got o_valid=%0b expected ok=1 o_valid=0", ok, got); end
        hs(3, 15'h0100, hc, ok);
        wait_out(got, oc, och, od);
        n_cmp++; if (!got || och != 3 || od !== 16'h0200) begin n_bad++; $display("FAIL restart_reload: got ch=%0d d=%h expected ch=3 d=0200", och, od); end
        // restart and grant to the same channel in one cycle: handshake completes, result dropped
        @(posedge clk); #1;
        bus.i_data[30 +: 15] = 15'h0300;
        bus.i_valid[2]       = 1'b1;
        bus.i_restart        = 1'b1;
        bus.i_restart_chan   = 2'd2;
        @(negedge clk);
        rdy = bus.o_ready[2];
        @(posedge clk); #1;
        bus.i_valid[2] = 1'b0;
        bus.i_restart  = 1'b0;
        n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL restart_same_ready: got %b expected 1", rdy); end
        wait_out(got, oc, och, od);
        n_cmp++; if (got) begin n_bad++; $display("FAIL restart_same_drop: got o_valid=1 ch=%0d expected none", och); end
    endtask

    task automatic test_reset_mid();
        int hc, oc, och, seen; bit ok, got; logic [15:0] od;
        for (int c = 0; c < 4; c++) bus.i_data[c*15 +: 15] = 15'h0100;
        @(posedge clk); #1;
        bus.i_valid = 4'b1111;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.o_ready !== 4'b0000) begin n_bad++; $display("FAIL midrst_ready: got %b expected 0000", bus.o_ready); end
        @(posedge clk); #1;
        rst         = 1'b0;
        bus.i_valid = '0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.o_valid) seen++;
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL midrst_novalid: got %0d strobes expected 0", seen); end
        n_cmp++; if (bus.o_data !== 16'h0000 || bus.o_chan !== 2'd0) begin n_bad++; $display("FAIL midrst_outs: got ch=%0d d=%h expected ch=0 d=0000", bus.o_chan, bus.o_data); end
        hs(0, 15'h0300, hc, ok);
        wait_out(got, oc, och, od);
        n_cmp++; if (!got || och != 0 || od !== 16'h0600 || oc - hc != 3) begin n_bad++; $display("FAIL midrst_reload: got ch=%0d d=%h lat=%0d expected ch=0 d=0600 lat=3", och, od, oc - hc); end
    endtask

    initial begin
        bus.i_valid        = '0;
        bus.i_data         = '0;
        bus.i_restart      = 1'b0;
        bus.i_restart_chan = '0;
        test_reset();
        test_basic();
        test_gear();
        test_round_robin();
        test_back_to_back();
        test_restart();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
